// File: rtl/gates_if.sv
// Stimulus/response bundle between the exerciser and the gates block.
interface gates_if;
  logic a;
  logic b;
  logic y1;
  logic y2;
  logic y3;
  logic y4;
  logic y5;
  logic y6;
  logic y7;

  modport master (output a, output b,
                  input y1, input y2, input y3, input y4, input y5, input y6, input y7);
  modport slave  (input a, input b,
                  output y1, output y2, output y3, output y4, output y5, output y6, output y7);
endinterface

// File: rtl/gates_exerciser.sv
// Walks the gates block through all four a/b combinations, samples y1..y7
// after a settle delay and reports pass/fail with per-combination detail.
//
// state  | meaning
// IDLE   | waiting for start, a=b=0
// SETTLE | holding a/b for the current combo while gates outputs settle
// SAMPLE | one cycle: compare y against the expected vector, advance combo
// DONE   | results valid and held, a=b=1, start re-arms
module gates_exerciser #(
  parameter int unsigned SETTLE = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  gates_if.master       gif,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [2:0]    err_count,
  output logic [3:0]    err_mask,
  output logic [6:0]    fail_bits
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

  state_t     state, state_nxt;
  logic [1:0] combo, combo_nxt, combo_inc;
  logic [3:0] cnt, cnt_nxt;
  logic       a_q, b_q, a_nxt, b_nxt;
  logic       busy_nxt, done_nxt, pass_nxt;
  logic [2:0] ec_nxt;
  logic [3:0] mask_nxt;
  logic [6:0] fb_nxt;
  logic [6:0] y_vec, exp_y, diff;

  assign gif.a     = a_q;
  assign gif.b     = b_q;
  assign y_vec     = {gif.y7, gif.y6, gif.y5, gif.y4, gif.y3, gif.y2, gif.y1};
  assign diff      = y_vec ^ exp_y;
  assign combo_inc = combo + 2'd1;

  // Bit order {XNOR, XOR, NOR, NAND, NOT a, OR, AND}
  always_comb begin
    exp_y = 7'h43;
    case (combo)
      2'd0:    exp_y = 7'h5C;
      2'd1:    exp_y = 7'h2E;
      2'd2:    exp_y = 7'h2A;
      default: exp_y = 7'h43;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      combo     <= 2'd0;
      cnt       <= 4'd0;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
      err_mask  <= 4'd0;
      fail_bits <= 7'd0;
    end else begin
      state     <= state_nxt;
      combo     <= combo_nxt;
      cnt       <= cnt_nxt;
      a_q       <= a_nxt;
      b_q       <= b_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
      err_count <= ec_nxt;
      err_mask  <= mask_nxt;
      fail_bits <= fb_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    combo_nxt = combo;
    cnt_nxt   = cnt;
    a_nxt     = a_q;
    b_nxt     = b_q;
    busy_nxt  = busy;
    done_nxt  = done;
    pass_nxt  = pass;
    ec_nxt    = err_count;
    mask_nxt  = err_mask;
    fb_nxt    = fail_bits;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_SETTLE;
          combo_nxt = 2'd0;
          cnt_nxt   = SETTLE_LD;
          a_nxt     = 1'b0;
          b_nxt     = 1'b0;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
          pass_nxt  = 1'b0;
          ec_nxt    = 3'd0;
          mask_nxt  = 4'd0;
          fb_nxt    = 7'd0;
        end
      end
      S_SETTLE: begin
        if (cnt == 4'd0) state_nxt = S_SAMPLE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      S_SAMPLE: begin
        if (diff != 7'd0) begin
          mask_nxt[combo] = 1'b1;
          ec_nxt          = err_count + 3'd1;
          fb_nxt          = fail_bits | diff;
        end
        if (combo != 2'd3) begin
          state_nxt = S_SETTLE;
          combo_nxt = combo_inc;
          cnt_nxt   = SETTLE_LD;
          a_nxt     = combo_inc[1];
          b_nxt     = combo_inc[0];
        end else begin
          // pass is decided on the final sample, including its own result
          state_nxt = S_DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          pass_nxt  = (ec_nxt == 3'd0);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_gates_exerciser.sv
// Scoreboard bench: a faulty-gates model feeds the exerciser, expected reports
// are queued at start and checked when done rises.
module tb_gates_exerciser;
  localparam int S   = 2;
  localparam int RUN = 4 * (S + 1);

  typedef struct {
    int         done_edge;
    logic       pass;
    logic [2:0] ec;
    logic [3:0] mask;
    logic [6:0] fb;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start, start1;
  logic busy, done, pass, busy1, done1, pass1;
  logic [2:0] err_count, err_count1;
  logic [3:0] err_mask, err_mask1;
  logic [6:0] fail_bits, fail_bits1;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  int         fault_mode = 0;
  bit         glitch_on = 1'b0;
  int         run_start = -1000;
  logic [6:0] rnd_mask [4];

  gates_if gi ();
  gates_if gi1 ();

  gates_exerciser #(.SETTLE(S)) u_dut (
    .clk(clk), .rst(rst), .start(start), .gif(gi),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .err_mask(err_mask), .fail_bits(fail_bits)
  );

  gates_exerciser #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .gif(gi1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err_count1), .err_mask(err_mask1), .fail_bits(fail_bits1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // bit6..bit0 = y7..y1
  function automatic logic [6:0] good_y(logic a, logic b);
    return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
  endfunction

  function automatic logic [6:0] faulty_y(logic [6:0] y, int k);
    case (fault_mode)
      1:       return y & 7'b1111011;
      2:       return {y[5], y[6], y[4:0]};
      3:       return y ^ rnd_mask[k];
      default: return y;
    endcase
  endfunction

  assign gi1.y1 = gi1.a & gi1.b;
  assign gi1.y2 = gi1.a | gi1.b;
  assign gi1.y3 = ~gi1.a;
  assign gi1.y4 = ~(gi1.a & gi1.b);
  assign gi1.y5 = ~(gi1.a | gi1.b);
  assign gi1.y6 = gi1.a ^ gi1.b;
  assign gi1.y7 = ~(gi1.a ^ gi1.b);

  // Outside the sampling cycles the response may be garbage when glitching
  always @(negedge clk) begin
    logic [6:0] y;
    int d;
    d = cyc + 1 - run_start;
    y = faulty_y(good_y(gi.a, gi.b), int'({gi.a, gi.b}));
    if (glitch_on && !(d >= S + 1 && d <= RUN && (d % (S + 1)) == 0))
      y = 7'($urandom);
    {gi.y7, gi.y6, gi.y5, gi.y4, gi.y3, gi.y2, gi.y1} = y;
  end

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  int   busy_cnt = 0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_cnt  = 0;
      prev_done = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (done && !prev_done) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done=1 expected no pending run (edge %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("done_latency", cyc, e.done_edge);
          check("busy_cycles", busy_cnt, RUN);
          check("pass", int'(pass), int'(e.pass));
          check("err_count", int'(err_count), int'(e.ec));
          check("err_mask", int'(err_mask), int'(e.mask));
          check("fail_bits", int'(fail_bits), int'(e.fb));
        end
        busy_cnt = 0;
      end
      if (done) check("ab_in_done", int'({gi.a, gi.b}), 3);
      prev_done = done;
    end
  end

  task automatic launch(int mode, bit glitch);
    exp_t e;
    logic [6:0] g, d;
    fault_mode = mode;
    glitch_on  = glitch;
    for (int k = 0; k < 4; k++) rnd_mask[k] = ($urandom_range(0, 2) == 0) ? 7'd0 : 7'($urandom);
    e.mask = 4'd0;
    e.ec   = 3'd0;
    e.fb   = 7'd0;
    for (int k = 0; k < 4; k++) begin
      g = good_y(k[1], k[0]);
      d = faulty_y(g, k) ^ g;
      if (d != 7'd0) begin
        e.mask[k] = 1'b1;
        e.ec      = e.ec + 3'd1;
        e.fb      = e.fb | d;
      end
    end
    e.pass      = (e.ec == 3'd0);
    run_start   = cyc + 1;
    e.done_edge = run_start + RUN;
    sb.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done expected done within %0d edges", RUN);
      sb.delete();
    end
  endtask

  task automatic run(int mode, bit glitch, bit extra);
    launch(mode, glitch);
    if (extra) begin
      repeat ($urandom_range(0, RUN - 1)) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle();
    repeat ($urandom_range(1, 4)) @(negedge clk);
  endtask

  task automatic check_zero(string name);
    check(name, int'({gi.a, gi.b, busy, done, pass, err_count, err_mask, fail_bits}), 0);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run(0, 1'b0, 1'b0);
    run(1, 1'b0, 1'b0);
    run(2, 1'b0, 1'b0);
    run(0, 1'b1, 1'b1);
    // back-to-back start while in DONE
    launch(2, 1'b1);
    wait_idle();
    launch(2, 1'b0);
    wait_idle();

    // reset during combo 2 settle
    launch(3, 1'b0);
    while (cyc < run_start + 2 * (S + 1) + 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("mid_run_reset");
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    run(0, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++)
      run(int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));

    // SETTLE=1 instance: done 8 edges after the start edge, busy for 8 cycles
    begin
      int n, t, bc;
      n  = cyc + 1;
      bc = 0;
      t  = 0;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      while (!done1 && t < 40) begin
        if (busy1) bc++;
        @(negedge clk);
        t++;
      end
      check("s1_done_latency", cyc, n + 8);
      check("s1_busy_cycles", bc, 8);
      check("s1_result", int'({pass1, err_count1, err_mask1, fail_bits1}), 1 << 14);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gates_exerciser.md
Name: gates_exerciser

Overview:
- Self-checking stimulus stage sitting directly upstream of the `gates` block.
- Drives `gates` inputs `a`/`b` through all four combinations (00, 01, 10, 11).
- After a settle delay, samples the seven `gates` outputs `y1..y7` and compares them against built-in expected values.
- Reports pass/fail, a per-combination error mask and the failing output bits; used for on-chip bring-up of the gate library.

Parameters:
- SETTLE, default 2: cycles `a`/`b` are held before `y1..y7` are sampled; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle request to begin a run; sampled only in IDLE or DONE.
- a  output  1  stimulus to `gates` `a`; registered.
- b  output  1  stimulus to `gates` `b`; registered.
- y1..y7  input  1 each  responses from `gates`: AND, OR, NOT a, NAND, NOR, XOR, XNOR.
- busy  output  1  high while a run is in progress.
- done  output  1  high in DONE state; sticky until next start or reset.
- pass  output  1  valid when done=1; 1 = no mismatches.
- err_count  output  3  number of failing combinations, 0..4.
- err_mask  output  4  bit i set = combination i failed (i = {a,b}).
- fail_bits  output  7  OR of mismatching bit positions over the run; bit0=y1 ... bit6=y7.

Behaviour:
- Reset, when rst=1 at a clock edge:
  - state=IDLE; a=b=0; busy=done=pass=0.
  - err_count=0, err_mask=0, fail_bits=0; internal combo index and settle counter cleared.
  - Reset has priority over every other event, including mid-run. No partial results are kept.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - a=b=0, busy=0.
  - start=1 at edge N → SETTLE, combo=0, a=b=0, busy=1 from N+1.
  - err_count, err_mask and fail_bits clear at the same edge.
- SETTLE:
  - Holds a=combo[1], b=combo[0] for exactly SETTLE cycles, counted by a settle counter.
  - Then → SAMPLE.
- SAMPLE:
  - One cycle; compares the 7-bit vector {y7..y1} against the expected value:
    - combo0 (a=0,b=0) = 7'h5C
    - combo1 (a=0,b=1) = 7'h2E
    - combo2 (a=1,b=0) = 7'h2A
    - combo3 (a=1,b=1) = 7'h43
  - On mismatch: err_mask[combo]=1, err_count+=1, fail_bits |= (actual ^ expected).
  - If combo<3: combo+=1 and → SETTLE; new a/b are driven from the next cycle.
  - If combo==3: → DONE.
- Timing:
  - Each combination occupies SETTLE+1 cycles.
  - start at edge N gives done=1 from N+1+4*(SETTLE+1)-1+1 = N+4*(SETTLE+1)+1.
  - For SETTLE=2, done rises 13 edges after the start edge; busy is high for 12 cycles.
- DONE:
  - busy=0, done=1.
  - pass = (err_count==0), registered on entry.
  - a/b hold 1/1; results hold.
  - start=1 → behaves exactly as start in IDLE: clears results, done=0, restarts at combo0.
- start while busy (SETTLE or SAMPLE): ignored; run continues unaltered.
- `y` inputs are ignored except in SAMPLE; glitches during SETTLE have no effect.
- err_count saturates naturally at 4 because there are only four samples; no wrap.
- Outputs are registered; no combinational path from `y*` or start to any output.

Test Plan:
- Correct `gates` instance, SETTLE=2, start pulse at cycle 5:
  - busy=1 for cycles 6..17; a/b sequence 00,01,10,11, each held 3 cycles.
  - done=1 from cycle 18; pass=1, err_count=0, err_mask=4'b0000, fail_bits=7'h00.
- y3 stuck at 0 (others correct):
  - err_mask=4'b0011, err_count=2, fail_bits=7'b0000100, pass=0.
- y6/y7 swapped (XOR↔XNOR):
  - All four combos fail; err_mask=4'b1111, err_count=4, fail_bits=7'b1100000, pass=0.
- Reset mid-run: assert rst while combo=2 in SETTLE:
  - Next edge: a=b=0, busy=0, done=0, err_count=0, err_mask=0.
  - A following start runs a full clean 12-cycle pass.
- start re-pulsed at cycle 9 during the run → ignored; done still rises at cycle 18.
  - A second start in DONE clears done next cycle and repeats identical results.
- SETTLE=1, correct `gates`: each combo held 2 cycles; done rises 9 edges after start; pass=1.
